// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU result FIFOs with round-robin arbitration onto the common data bus
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   {alu,mem,br}_valid_i/_rob_tag_i/_pd_i/_has_dest_i/_data_i   FU results
//   {alu,mem,br}_stall_o                issue back-pressure per FU
//   curr_rob_tag_i                      ROB head tag, age reference
//   mispredict_i, mispredict_tag_i      flush of results younger than the branch
//   cdb_valid_o/_rob_tag_o/_pd_o/_data_o/_prf_we_o   registered broadcast
//   overflow_err_o                      sticky push-into-full flag
// Optional: CDB_BYPASS_EN lets an input skip its empty FIFO straight into the CDB register.
module cdb_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STALL_MARGIN = 2,
  parameter int PREG_W       = 7,
  parameter int TAG_W        = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              alu_valid_i,
  input  logic [TAG_W-1:0]  alu_rob_tag_i,
  input  logic [PREG_W-1:0] alu_pd_i,
  input  logic              alu_has_dest_i,
  input  logic [31:0]       alu_data_i,
  output logic              alu_stall_o,
  input  logic              mem_valid_i,
  input  logic [TAG_W-1:0]  mem_rob_tag_i,
  input  logic [PREG_W-1:0] mem_pd_i,
  input  logic              mem_has_dest_i,
  input  logic [31:0]       mem_data_i,
  output logic              mem_stall_o,
  input  logic              br_valid_i,
  input  logic [TAG_W-1:0]  br_rob_tag_i,
  input  logic [PREG_W-1:0] br_pd_i,
  input  logic              br_has_dest_i,
  input  logic [31:0]       br_data_i,
  output logic              br_stall_o,
  input  logic [TAG_W-1:0]  curr_rob_tag_i,
  input  logic              mispredict_i,
  input  logic [TAG_W-1:0]  mispredict_tag_i,
  output logic              cdb_valid_o,
  output logic [TAG_W-1:0]  cdb_rob_tag_o,
  output logic [PREG_W-1:0] cdb_pd_o,
  output logic [31:0]       cdb_data_o,
  output logic              cdb_prf_we_o,
  output logic              overflow_err_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NF = 3;
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [PREG_W-1:0] pd;
    logic              hd;
    logic [31:0]       data;
  } ent_t;
  ent_t                  mem_q [NF][FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] live_q [NF];
  logic [FIFO_DEPTH-1:0] live_d [NF];
  logic [AW-1:0]         rd_q [NF];
  logic [AW-1:0]         wr_q [NF];
  logic [AW:0]           cnt_q [NF];
  ent_t                  in_e [NF];
  logic [NF-1:0]         in_v, in_live, full, head_live, dead_pop, byp, cand, cand_r, push, pop;
  logic [1:0]            ptr_q, ptr_d, off, win;
  logic [2:0]            sum;
  logic                  grant;
  ent_t                  cdb_q, cdb_d;
  logic                  cdb_v_q, we_q, we_d, ovf_q, ovf_d;

  // Age is measured from the ROB head modulo 2^TAG_W; larger age means younger.
  function automatic logic younger(input logic [TAG_W-1:0] t, h, m);
    logic [TAG_W-1:0] a, b;
    a = t - h;
    b = m - h;
    return a > b;
  endfunction

  always_comb begin
    in_e[0] = {alu_rob_tag_i, alu_pd_i, alu_has_dest_i, alu_data_i};
    in_e[1] = {mem_rob_tag_i, mem_pd_i, mem_has_dest_i, mem_data_i};
    in_e[2] = {br_rob_tag_i, br_pd_i, br_has_dest_i, br_data_i};
    in_v    = {br_valid_i, mem_valid_i, alu_valid_i};
    for (int f = 0; f < NF; f++) begin
      in_live[f] = in_v[f] && !(mispredict_i && younger(in_e[f].tag, curr_rob_tag_i, mispredict_tag_i));
      for (int i = 0; i < FIFO_DEPTH; i++)
        live_d[f][i] = live_q[f][i] &&
                       !(mispredict_i && younger(mem_q[f][i].tag, curr_rob_tag_i, mispredict_tag_i));
      head_live[f] = cnt_q[f] != '0 && live_d[f][rd_q[f]];
      dead_pop[f]  = cnt_q[f] != '0 && !live_d[f][rd_q[f]];
      full[f]      = cnt_q[f] == (AW+1)'(FIFO_DEPTH);
`ifdef CDB_BYPASS_EN
      byp[f]       = cnt_q[f] == '0 && in_live[f];
`else
      byp[f]       = 1'b0;
`endif
      cand[f]      = head_live[f] || byp[f];
    end
    // Rotate candidates so bit 0 is the FU at the RR pointer, then take the first set bit.
    cand_r = ptr_q == 2'd0 ? cand : ptr_q == 2'd1 ? {cand[0], cand[2:1]} : {cand[1:0], cand[2]};
    off    = cand_r[0] ? 2'd0 : cand_r[1] ? 2'd1 : 2'd2;
    grant  = |cand;
    sum    = {1'b0, ptr_q} + {1'b0, off};
    win    = sum >= 3'd3 ? 2'(sum - 3'd3) : sum[1:0];
    for (int f = 0; f < NF; f++) begin
      pop[f]  = dead_pop[f] || (grant && win == 2'(f) && head_live[f]);
      push[f] = in_live[f] && !full[f] && !(grant && win == 2'(f) && byp[f]);
    end
    cdb_d = grant ? (byp[win] ? in_e[win] : mem_q[win][rd_q[win]]) : cdb_q;
    we_d  = grant && cdb_d.hd && cdb_d.pd != '0;
    ptr_d = grant ? (win == 2'd2 ? 2'd0 : win + 2'd1) : ptr_q;
    ovf_d = ovf_q || |(in_live & full);
  end

  always_ff @(posedge clk_i)
    for (int f = 0; f < NF; f++)
      if (push[f]) mem_q[f][wr_q[f]] <= in_e[f];

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int f = 0; f < NF; f++) begin
        live_q[f] <= '0;
        rd_q[f]   <= '0;
        wr_q[f]   <= '0;
        cnt_q[f]  <= '0;
      end
      ptr_q   <= '0;
      cdb_q   <= '0;
      cdb_v_q <= 1'b0;
      we_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      for (int f = 0; f < NF; f++) begin
        live_q[f] <= live_d[f];
        if (push[f]) live_q[f][wr_q[f]] <= 1'b1;
        rd_q[f]  <= rd_q[f] + AW'(pop[f]);
        wr_q[f]  <= wr_q[f] + AW'(push[f]);
        cnt_q[f] <= cnt_q[f] + (AW+1)'(push[f]) - (AW+1)'(pop[f]);
      end
      ptr_q   <= ptr_d;
      cdb_q   <= cdb_d;
      cdb_v_q <= grant;
      we_q    <= we_d;
      ovf_q   <= ovf_d;
    end

  assign alu_stall_o    = cnt_q[0] >= (AW+1)'(FIFO_DEPTH - STALL_MARGIN);
  assign mem_stall_o    = cnt_q[1] >= (AW+1)'(FIFO_DEPTH - STALL_MARGIN);
  assign br_stall_o     = cnt_q[2] >= (AW+1)'(FIFO_DEPTH - STALL_MARGIN);
  assign cdb_valid_o    = cdb_v_q;
  assign cdb_rob_tag_o  = cdb_q.tag;
  assign cdb_pd_o       = cdb_q.pd;
  assign cdb_data_o     = cdb_q.data;
  assign cdb_prf_we_o   = we_q;
  assign overflow_err_o = ovf_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: randomized and directed stimulus against a queue-based reference model
module tb_cdb_arbiter;
  localparam int DEPTH = 4;
  localparam int THR   = 2;
  typedef struct {
    logic [4:0]  tag;
    logic [6:0]  pd;
    logic        hd;
    logic [31:0] data;
    bit          live;
  } ment_t;

  logic        clk = 1'b0, rst_ni = 1'b0;
  logic        v [3];
  logic [4:0]  tg [3];
  logic [6:0]  pd [3];
  logic        hd [3];
  logic [31:0] dt [3];
  logic        stall [3];
  logic [4:0]  cur = '0, mt = '0;
  logic        mp = 1'b0;
  logic        cdb_valid, cdb_we, ovf;
  logic [4:0]  cdb_tag;
  logic [6:0]  cdb_pd;
  logic [31:0] cdb_data;

  ment_t       q [3][$];
  int          ptr;
  logic        e_v, e_we, e_ovf;
  logic [4:0]  e_tag;
  logic [6:0]  e_pd;
  logic [31:0] e_data;
  int          checks = 0, errors = 0;

  cdb_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .alu_valid_i(v[0]), .alu_rob_tag_i(tg[0]), .alu_pd_i(pd[0]), .alu_has_dest_i(hd[0]),
    .alu_data_i(dt[0]), .alu_stall_o(stall[0]),
    .mem_valid_i(v[1]), .mem_rob_tag_i(tg[1]), .mem_pd_i(pd[1]), .mem_has_dest_i(hd[1]),
    .mem_data_i(dt[1]), .mem_stall_o(stall[1]),
    .br_valid_i(v[2]), .br_rob_tag_i(tg[2]), .br_pd_i(pd[2]), .br_has_dest_i(hd[2]),
    .br_data_i(dt[2]), .br_stall_o(stall[2]),
    .curr_rob_tag_i(cur), .mispredict_i(mp), .mispredict_tag_i(mt),
    .cdb_valid_o(cdb_valid), .cdb_rob_tag_o(cdb_tag), .cdb_pd_o(cdb_pd), .cdb_data_o(cdb_data),
    .cdb_prf_we_o(cdb_we), .overflow_err_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int age(input logic [4:0] t);
    return (int'(t) - int'(cur) + 32) % 32;
  endfunction

  function automatic bit young(input logic [4:0] t);
    return mp && age(t) > age(mt);
  endfunction

  task automatic model_reset();
    for (int f = 0; f < 3; f++) q[f].delete();
    ptr = 0; e_v = 0; e_we = 0; e_ovf = 0; e_tag = '0; e_pd = '0; e_data = '0;
  endtask

  // One clock of the reference: flush, arbitrate, drop dead heads, then accept inputs.
  task automatic model_step();
    int sz [3];
    bit inl [3], byp [3], cand [3], popped [3];
    int win;
    ment_t w;
    for (int f = 0; f < 3; f++) begin
      sz[f] = q[f].size();
      foreach (q[f][i]) if (young(q[f][i].tag)) q[f][i].live = 0;
      inl[f] = v[f] && !young(tg[f]);
      byp[f] = 0;
`ifdef CDB_BYPASS_EN
      byp[f] = sz[f] == 0 && inl[f];
`endif
      cand[f] = (sz[f] > 0 && q[f][0].live) || byp[f];
      popped[f] = 0;
    end
    win = -1;
    for (int k = 0; k < 3; k++) if (win < 0 && cand[(ptr + k) % 3]) win = (ptr + k) % 3;
    e_v = 0; e_we = 0;
    if (win >= 0) begin
      if (byp[win]) w = '{tg[win], pd[win], hd[win], dt[win], 1'b1};
      else begin w = q[win].pop_front(); popped[win] = 1; end
      e_v = 1; e_tag = w.tag; e_pd = w.pd; e_data = w.data; e_we = w.hd && w.pd != 0;
      ptr = (win + 1) % 3;
    end
    for (int f = 0; f < 3; f++) begin
      if (!popped[f] && sz[f] > 0 && !q[f][0].live) void'(q[f].pop_front());
      if (inl[f] && !(win == f && byp[f])) begin
        if (sz[f] == DEPTH) e_ovf = 1;
        else q[f].push_back('{tg[f], pd[f], hd[f], dt[f], 1'b1});
      end
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ".cdb_valid"}, cdb_valid, e_v);
    check({ph, ".cdb_tag"}, cdb_tag, e_tag);
    check({ph, ".cdb_pd"}, cdb_pd, e_pd);
    check({ph, ".cdb_data"}, cdb_data, e_data);
    check({ph, ".prf_we"}, cdb_we, e_we);
    check({ph, ".overflow"}, ovf, e_ovf);
    for (int f = 0; f < 3; f++) check($sformatf("%s.stall%0d", ph, f), stall[f], q[f].size() >= THR);
  endtask

  task automatic cycle(input string ph);
    @(posedge clk);
    model_step();
    #1;
    check_all(ph);
  endtask

  task automatic idle();
    for (int f = 0; f < 3; f++) begin v[f] = 0; tg[f] = '0; pd[f] = '0; hd[f] = 0; dt[f] = '0; end
    mp = 0;
  endtask

  task automatic put(input int f, input logic [4:0] t, input logic [6:0] p, input logic h,
                     input logic [31:0] d);
    v[f] = 1; tg[f] = t; pd[f] = p; hd[f] = h; dt[f] = d;
  endtask

  task automatic drive_rand(input int pct, input bit honor);
    for (int f = 0; f < 3; f++) begin
      v[f]  = $urandom_range(0, 99) < pct && !(honor && q[f].size() >= THR);
      tg[f] = 5'($urandom);
      pd[f] = $urandom_range(0, 3) == 0 ? 7'd0 : 7'($urandom);
      hd[f] = 1'($urandom);
      dt[f] = $urandom;
    end
    mp = $urandom_range(0, 15) == 0;
    mt = 5'($urandom);
    if ($urandom_range(0, 7) == 0) cur = 5'($urandom);
  endtask

  initial begin
    idle();
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk) rst_ni = 1;

    put(0, 5'd3, 7'd10, 1, 32'hDEADBEEF);
    cycle("alu_single");
    idle();
    for (int i = 0; i < 3; i++) cycle("alu_single");

    for (int t = 0; t < 2; t++) begin
      for (int f = 0; f < 3; f++) put(f, 5'(1 + 3 * t + f), 7'(20 + f), 1, 32'(100 * t + f));
      cycle("trio");
      idle();
      for (int i = 0; i < 4; i++) cycle("trio");
    end
    put(0, 5'd12, 7'd5, 1, 32'h55);
    cycle("ptr_mem");
    idle();
    for (int i = 0; i < 3; i++) cycle("ptr_mem");
    for (int f = 0; f < 3; f++) put(f, 5'(7 + f), 7'(30 + f), 1, 32'(200 + f));
    cycle("trio_mem");
    idle();
    for (int i = 0; i < 4; i++) cycle("trio_mem");

    cur = 5'd0;
    put(0, 5'd2, 7'd1, 1, 32'h2); put(1, 5'd0, 7'd2, 1, 32'h20); put(2, 5'd1, 7'd3, 1, 32'h21);
    cycle("flush");
    idle(); put(0, 5'd5, 7'd4, 1, 32'h5);
    cycle("flush");
    idle(); put(0, 5'd7, 7'd6, 1, 32'h7);
    cycle("flush");
    idle(); mp = 1; mt = 5'd4;
    cycle("flush");
    idle();
    for (int i = 0; i < 4; i++) cycle("flush");

    put(1, 5'd9, 7'd0, 1, 32'h90);
    cycle("no_we");
    idle(); put(1, 5'd10, 7'd11, 0, 32'h91);
    cycle("no_we");
    idle();
    for (int i = 0; i < 3; i++) cycle("no_we");

    for (int i = 0; i < 1500; i++) begin drive_rand(45, 1); cycle("rand"); end
    for (int i = 0; i < 20; i++) begin
      for (int f = 0; f < 3; f++) put(f, 5'($urandom), 7'($urandom), 1, $urandom);
      mp = 0;
      cycle("flood");
    end
    for (int i = 0; i < 300; i++) begin drive_rand(70, 0); cycle("rand_nostall"); end

    drive_rand(90, 0);
    rst_ni = 0;
    #1;
    model_reset();
    check_all("mid_reset");
    idle();
    @(negedge clk) rst_ni = 1;
    put(2, 5'd17, 7'd33, 1, 32'hCAFE);
    cycle("post_reset");
    idle();
    for (int i = 0; i < 3; i++) cycle("post_reset");
    for (int i = 0; i < 500; i++) begin drive_rand(40, 1); cycle("rand2"); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
